fb_arbiter: RTL

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_arbiter_pkg.sv | 24 ++
 rtl/fb_wr_fifo.sv | 66 ++++++
 rtl/fb_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fb_arbiter_pkg.sv
// fb_arbiter_pkg -- shared definitions for the frame-buffer arbiter slice.
//   FB_AW_DEFAULT / FB_DW_DEFAULT : default address / pixel widths
//   RD_LATENCY                    : rd_req to rd_valid distance in cycles
//   WRBUF_DEPTH                   : write FIFO depth (FB_ARB_WRBUF_EN builds)
//   fb_state_e                    : RAM issue state (IDLE / READ / WRITE)
package fb_arbiter_pkg;

    localparam int unsigned FB_AW_DEFAULT = 19;
    localparam int unsigned FB_DW_DEFAULT = 12;
    localparam int unsigned RD_LATENCY    = 2;
    localparam int unsigned WRBUF_DEPTH   = 2;

    // Legacy encodings kept so external tools keyed on the old values still match.
    localparam logic [1:0] IDLE_ENC  = 2'd0;
    localparam logic [1:0] READ_ENC  = 2'd1;
    localparam logic [1:0] WRITE_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE_ENC,
        ST_READ  = READ_ENC,
        ST_WRITE = WRITE_ENC
    } fb_state_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo -- small write-buffer FIFO used by fb_arbiter when FB_ARB_WRBUF_EN
// is defined. Depth is WRBUF_DEPTH from fb_arbiter_pkg.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   push        : store push_data (ignored when full)
//   push_data   : W-bit entry
//   pop         : discard the head entry (ignored when empty)
//   head        : current head entry (valid while !empty)
//   full, empty : occupancy flags
module fb_wr_fifo
    import fb_arbiter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PW = (WRBUF_DEPTH > 1) ? $clog2(WRBUF_DEPTH) : 1;
    localparam int unsigned CW = $clog2(WRBUF_DEPTH + 1);

    logic [W-1:0]  slots [WRBUF_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(WRBUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(WRBUF_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only visible after being pushed.
    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter -- single-port frame-buffer RAM arbiter. The display scan-out
// read port has strict priority; drawing-engine writes use idle slots.
// Optional feature macro: FB_ARB_WRBUF_EN (adds a 2-entry write FIFO).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   rd_req, rd_addr     : display read request / address (one pixel per cycle)
//   rd_valid, rd_data   : returned pixel, 2 cycles after rd_req
//   wr_valid, wr_ready  : write handshake (accept when both high)
//   wr_addr, wr_data    : write address / pixel
//   wr_pending          : an accepted write has not yet been issued to RAM
//   mem_en, mem_we      : registered RAM strobe / write enable
//   mem_addr, mem_wdata : registered RAM address / write data
//   mem_rdata           : synchronous RAM read data (1 cycle after a read)
module fb_arbiter
    import fb_arbiter_pkg::*;
#(
    parameter int AW = FB_AW_DEFAULT,
    parameter int DW = FB_DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          wr_pending
);

    fb_state_e     state;
    fb_state_e     next_state;
    logic          run;
    logic          wr_avail;
    logic [AW-1:0] wr_head_addr;
    logic [DW-1:0] wr_head_data;

`ifdef FB_ARB_WRBUF_EN
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic [AW+DW-1:0]   fifo_head;

    // Acceptance depends only on FIFO space; the display never blocks it.
    assign wr_ready   = run & ~fifo_full;
    assign fifo_push  = wr_valid & wr_ready;
    assign fifo_pop   = ~rd_req & ~fifo_empty;
    assign wr_avail   = ~fifo_empty;
    assign wr_pending = ~fifo_empty;
    assign {wr_head_addr, wr_head_data} = fifo_head;

    fb_wr_fifo #(
        .W(AW + DW)
    ) u_wr_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({wr_addr, wr_data}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
`else
    // Unbuffered: a write is only taken in a cycle whose next slot is free,
    // so it issues directly on the following cycle.
    assign wr_ready     = run & ~rd_req;
    assign wr_avail     = wr_valid & wr_ready;
    assign wr_pending   = wr_avail;
    assign wr_head_addr = wr_addr;
    assign wr_head_data = wr_data;
`endif

    always_comb begin
        next_state = ST_IDLE;
        if (rd_req)
            next_state = ST_READ;
        else if (wr_avail)
            next_state = ST_WRITE;
    end

    // run keeps wr_ready low while in reset and for the release cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            state     <= ST_IDLE;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_valid  <= 1'b0;
        end else begin
            run      <= 1'b1;
            state    <= next_state;
            mem_en   <= (next_state != ST_IDLE);
            mem_we   <= (next_state == ST_WRITE);
            case (next_state)
                ST_READ:  mem_addr <= rd_addr;
                ST_WRITE: begin
                    mem_addr  <= wr_head_addr;
                    mem_wdata <= wr_head_data;
                end
                default: ;
            endcase
            // READ occupies the cycle after rd_req; RAM data follows one later.
            rd_valid <= (state == ST_READ);
        end
    end

    assign rd_data = rd_valid ? mem_rdata : '0;

endmodule
